// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM state encoding
// and the small pure helpers that decode legality, byte enables and store data.
package riscv_lsu_pkg;

   localparam logic [2:0] LDST_B  = 3'd0;
   localparam logic [2:0] LDST_H  = 3'd1;
   localparam logic [2:0] LDST_W  = 3'd2;
   localparam logic [2:0] LDST_BU = 3'd4;
   localparam logic [2:0] LDST_HU = 3'd5;

   typedef logic [1:0] lsu_state_t;

   localparam lsu_state_t IDLE = 2'd0;
   localparam lsu_state_t REQ  = 2'd1;
   localparam lsu_state_t RESP = 2'd2;

   // Unsigned sizes only exist for loads; halfwords need even addresses,
   // words need word-aligned addresses.
   function automatic logic lsu_is_legal(input logic we,
                                         input logic [2:0] size,
                                         input logic [1:0] off);
      logic legal;
      legal = 1'b0;
      case (size)
         LDST_B:  legal = 1'b1;
         LDST_H:  legal = ~off[0];
         LDST_W:  legal = (off == 2'b00);
         LDST_BU: legal = ~we;
         LDST_HU: legal = ~we & ~off[0];
         default: legal = 1'b0;
      endcase
      return legal;
   endfunction

   // Byte lanes touched by an access of the given size at the given offset.
   function automatic logic [3:0] lsu_byte_enable(input logic [2:0] size,
                                                  input logic [1:0] off);
      logic [3:0] be;
      be = 4'b1111;
      case (size)
         LDST_B, LDST_BU: be = 4'b0001 << off;
         LDST_H, LDST_HU: be = 4'b0011 << {off[1], 1'b0};
         default:         be = 4'b1111;
      endcase
      return be;
   endfunction

   // Stores replicate the narrow datum into every lane so the byte enables
   // alone select where it lands.
   function automatic logic [31:0] lsu_store_data(input logic [2:0] size,
                                                  input logic [31:0] d);
      logic [31:0] wd;
      wd = d;
      case (size)
         LDST_B:  wd = {4{d[7:0]}};
         LDST_H:  wd = {2{d[15:0]}};
         default: wd = d;
      endcase
      return wd;
   endfunction

endpackage

// File: rtl/riscv_lsu_load_align.sv
// Picks the addressed byte/halfword out of a memory word and sign- or
// zero-extends it to XLEN according to the load size.
module riscv_lsu_load_align
   import riscv_lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [2:0]  size,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane selection followed by extension; word loads pass straight through.
   always_comb begin
      byte_sel = rdata[{off, 3'b000} +: 8];
      half_sel = rdata[{off[1], 4'b0000} +: 16];
      data     = rdata;
      case (size)
         LDST_B:  data = {{24{byte_sel[7]}}, byte_sel};
         LDST_BU: data = {24'h000000, byte_sel};
         LDST_H:  data = {{16{half_sel[15]}}, half_sel};
         LDST_HU: data = {16'h0000, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: turns the execute stage's memory request into a single
// req/gnt/rvalid transaction on word-wide data memory, stalls the core until
// it completes, and returns extended load data to write-back.
module riscv_lsu
   import riscv_lsu_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  logic [2:0]  lsu_size_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_data_i,
   output logic [31:0] lsu_data_o,
   output logic        lsu_stall_req_o,
   output logic        lsu_fault_o,
   output logic        data_req_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i
);

   lsu_state_t  state_q;
   logic        we_q;
   logic [3:0]  be_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [1:0]  off_q;
   logic [2:0]  size_q;
   logic [31:0] load_data_q;

   logic        legal;
   logic        fault;
   logic        resp_done;
   logic        load_done;
   logic [31:0] align_data;

   riscv_lsu_load_align u_load_align (
      .rdata (data_rdata_i),
      .off   (off_q),
      .size  (size_q),
      .data  (align_data)
   );

   // Request decode: a fault is only raised when a new op is sampled in IDLE.
   always_comb begin
      legal     = lsu_is_legal(lsu_we_i, lsu_size_i, lsu_addr_i[1:0]);
      fault     = (state_q == IDLE) & lsu_req_i & ~legal;
      resp_done = (state_q == RESP) & data_rvalid_i;
      load_done = resp_done & ~we_q;
   end

   // Core-facing outputs; the finishing load's data bypasses the register.
   always_comb begin
      lsu_fault_o     = fault;
      lsu_stall_req_o = lsu_req_i & ~fault & ~resp_done;
      lsu_data_o      = load_done ? align_data : load_data_q;
   end

   // Memory-facing outputs come straight from the captured request.
   always_comb begin
      data_req_o   = (state_q == REQ);
      data_we_o    = we_q;
      data_be_o    = be_q;
      data_addr_o  = addr_q;
      data_wdata_o = wdata_q;
   end

   // Transaction FSM and request capture; reset abandons any open transaction.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         be_q        <= 4'b0000;
         addr_q      <= 32'h0000_0000;
         wdata_q     <= 32'h0000_0000;
         off_q       <= 2'b00;
         size_q      <= LDST_B;
         load_data_q <= 32'h0000_0000;
      end else begin
         case (state_q)
            IDLE: begin
               if (lsu_req_i && legal) begin
                  we_q    <= lsu_we_i;
                  be_q    <= lsu_byte_enable(lsu_size_i, lsu_addr_i[1:0]);
                  addr_q  <= {lsu_addr_i[31:2], 2'b00};
                  wdata_q <= lsu_store_data(lsu_size_i, lsu_data_i);
                  off_q   <= lsu_addr_i[1:0];
                  size_q  <= lsu_size_i;
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (data_gnt_i) begin
                  state_q <= RESP;
               end
            end
            RESP: begin
               if (data_rvalid_i) begin
                  if (!we_q) begin
                     load_data_q <= align_data;
                  end
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
